// File: rtl/c4_pkg.sv
// c4_pkg: shared constants, state encoding and helpers for the Connect-4 turn sequencer.
package c4_pkg;
   localparam int ROWS    = 6;
   localparam int COLS    = 7;
   localparam int WIN_LAT = 3;
   localparam int CLR_CYC = 2;

   localparam logic       PLAYER1  = 1'b1;
   localparam logic       PLAYER2  = 1'b0;
   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_P1   = 2'd1;
   localparam logic [1:0] WIN_P2   = 2'd2;

   typedef enum logic [2:0] {
      ST_CLR   = 3'd0,
      ST_IDLE  = 3'd1,
      ST_WRITE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Board row to write address: each row occupies four address slots.
   function automatic logic [4:0] row_to_addr(input logic [2:0] row);
      return {row, 2'b00};
   endfunction
endpackage

// File: rtl/c4_col_heights.sv
// c4_col_heights: per-column fill counters; reports whether the selected column
// is full and which row a new disc in it would land on.
module c4_col_heights
   import c4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   input  logic [2:0] col,
   output logic       col_full,
   output logic [2:0] row
);
   logic [2:0]      height_r [COLS];
   logic [COLS-1:0] full_s;
   logic [2:0]      sel_height_s;
   logic            sel_full_s;

   // Fill counters: cleared on reset or new game, selected column bumped on a move.
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         for (int i = 0; i < COLS; i++) height_r[i] <= 3'd0;
      end else begin
         for (int i = 0; i < COLS; i++) begin
            if (inc && (col == 3'(i)) && !full_s[i]) height_r[i] <= height_r[i] + 3'd1;
            else                                      height_r[i] <= height_r[i];
         end
      end
   end

   // Per-column full flags.
   always_comb begin
      full_s = {COLS{1'b0}};
      for (int i = 0; i < COLS; i++) full_s[i] = (height_r[i] == 3'(ROWS));
   end

   // Column select; a column outside the board reads as full.
   always_comb begin
      sel_height_s = 3'(ROWS);
      sel_full_s   = 1'b1;
      for (int i = 0; i < COLS; i++) begin
         sel_height_s = (col == 3'(i)) ? height_r[i] : sel_height_s;
         sel_full_s   = (col == 3'(i)) ? full_s[i]   : sel_full_s;
      end
   end

   assign col_full = sel_full_s;
   assign row      = 3'(ROWS - 1) - sel_height_s;
endmodule

// File: rtl/c4_turn_ctrl.sv
// c4_turn_ctrl: Connect-4 game sequencer. Issues one board write per legal move,
// waits out the win-check latency, then decides win, draw or next turn.
module c4_turn_ctrl
   import c4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       new_game,
   input  logic       move_valid,
   input  logic [2:0] move_col,
   output logic       move_ready,
   output logic       illegal,
   output logic       Player,
   output logic [2:0] colval,
   output logic [4:0] waddr,
   output logic       wr_en,
   output logic       board_rst,
   input  logic       winflag,
   output logic       game_over,
   output logic [1:0] winner,
   output logic       draw,
   output logic [5:0] move_cnt
);
   state_t     state_r, next_state_s;
   logic [1:0] clr_cnt_r, wait_cnt_r;
   logic       accept_s, reject_s, win_s, draw_s;
   logic       col_full_s;
   logic [2:0] row_s;
   logic       move_ready_r, illegal_r, player_r, wr_en_r, board_rst_r;
   logic       game_over_r, draw_r;
   logic [2:0] colval_r;
   logic [4:0] waddr_r;
   logic [1:0] winner_r;
   logic [5:0] move_cnt_r;

   c4_col_heights u_heights (
      .clk      (clk),
      .rst      (rst),
      .clr      (next_state_s == ST_CLR),
      .inc      (accept_s),
      .col      (move_col),
      .col_full (col_full_s),
      .row      (row_s)
   );

   // Next-state and move decision; new_game overrides everything.
   always_comb begin
      next_state_s = state_r;
      accept_s     = 1'b0;
      reject_s     = 1'b0;
      win_s        = 1'b0;
      draw_s       = 1'b0;
      if (new_game) begin
         next_state_s = ST_CLR;
      end else begin
         case (state_r)
            ST_CLR:   next_state_s = (clr_cnt_r == 2'd0) ? ST_IDLE : ST_CLR;
            ST_IDLE: begin
               if (move_valid && move_ready_r) begin
                  if ((move_col >= 3'(COLS)) || col_full_s) begin
                     reject_s = 1'b1;
                  end else begin
                     accept_s     = 1'b1;
                     next_state_s = ST_WRITE;
                  end
               end else begin
                  next_state_s = ST_IDLE;
               end
            end
            ST_WRITE: next_state_s = ST_WAIT;
            ST_WAIT:  next_state_s = (wait_cnt_r == 2'd0) ? ST_CHECK : ST_WAIT;
            ST_CHECK: begin
               if (winflag) begin
                  win_s        = 1'b1;
                  next_state_s = ST_DONE;
               end else if (move_cnt_r == 6'(ROWS * COLS)) begin
                  draw_s       = 1'b1;
                  next_state_s = ST_DONE;
               end else begin
                  next_state_s = ST_IDLE;
               end
            end
            ST_DONE:  next_state_s = ST_DONE;
            default:  next_state_s = ST_CLR;
         endcase
      end
   end

   // State, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= ST_CLR;
         clr_cnt_r    <= 2'(CLR_CYC - 1);
         wait_cnt_r   <= 2'd0;
         move_ready_r <= 1'b0;
         illegal_r    <= 1'b0;
         player_r     <= PLAYER1;
         colval_r     <= 3'd0;
         waddr_r      <= 5'd0;
         wr_en_r      <= 1'b0;
         board_rst_r  <= 1'b0;
         game_over_r  <= 1'b0;
         winner_r     <= WIN_NONE;
         draw_r       <= 1'b0;
         move_cnt_r   <= 6'd0;
      end else begin
         state_r      <= next_state_s;
         move_ready_r <= (next_state_s == ST_IDLE);
         illegal_r    <= reject_s;
         wr_en_r      <= accept_s;
         board_rst_r  <= (next_state_s != ST_CLR);
         if (new_game || (state_r != ST_CLR)) clr_cnt_r <= 2'(CLR_CYC - 1);
         else                                 clr_cnt_r <= clr_cnt_r - 2'd1;
         if (state_r != ST_WAIT) wait_cnt_r <= 2'(WIN_LAT - 2);
         else                    wait_cnt_r <= wait_cnt_r - 2'd1;
         if (next_state_s == ST_CLR) begin
            move_cnt_r  <= 6'd0;
            winner_r    <= WIN_NONE;
            draw_r      <= 1'b0;
            game_over_r <= 1'b0;
            player_r    <= PLAYER1;
         end else if (accept_s) begin
            colval_r   <= move_col;
            waddr_r    <= row_to_addr(row_s);
            move_cnt_r <= move_cnt_r + 6'd1;
         end else if (win_s) begin
            winner_r    <= (player_r == PLAYER1) ? WIN_P1 : WIN_P2;
            game_over_r <= 1'b1;
         end else if (draw_s) begin
            draw_r      <= 1'b1;
            game_over_r <= 1'b1;
         end else if ((state_r == ST_CHECK) && (next_state_s == ST_IDLE)) begin
            player_r <= ~player_r;
         end else begin
            player_r <= player_r;
         end
      end
   end

   assign move_ready = move_ready_r;
   assign illegal    = illegal_r;
   assign Player     = player_r;
   assign colval     = colval_r;
   assign waddr      = waddr_r;
   assign wr_en      = wr_en_r;
   assign board_rst  = board_rst_r;
   assign game_over  = game_over_r;
   assign winner     = winner_r;
   assign draw       = draw_r;
   assign move_cnt   = move_cnt_r;
endmodule

// File: doc/c4_turn_ctrl.md
Name: c4_turn_ctrl

Overview:
Game sequencer for the Connect-4 board/win-check datapath.
- Accepts column requests from the input front end and computes the landing row from per-column fill counters.
- Drives one board write (Player, colval, waddr) per legal move into the win-check block, waits out its latency, then samples winflag.
- Decides win, draw or next turn, and handles new-game clearing of the datapath.

Parameters:
ROWS, 6, board rows (row 0 top, row ROWS-1 bottom)
COLS, 7, board columns
WIN_LAT, 3, clk cycles from write strobe to valid winflag
CLR_CYC, 2, cycles board_rst held low on new game

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
new_game  in  1  start new game; level-sampled each cycle
move_valid  in  1  column request valid
move_col  in  3  requested column
move_ready  out  1  controller can accept a move
illegal  out  1  one-cycle pulse: request rejected
Player  out  1  player owning current write (1 = player 1, 0 = player 2)
colval  out  3  column of current write
waddr  out  5  row address of current write = row*4
wr_en  out  1  one-cycle board write strobe
board_rst  out  1  active-low clear to board/win-check, CLR_CYC cycles
winflag  in  1  win indication from win-check
game_over  out  1  game finished (win or draw)
winner  out  2  0 none, 1 player1, 2 player2
draw  out  1  board full with no win
move_cnt  out  6  legal moves played this game, 0..42

Behaviour:
Reset (rst=0 at posedge):
- State = CLR with clear counter loaded; board_rst=0; all heights 0; move_cnt=0; Player=1.
- colval=0, waddr=0; wr_en, illegal, move_ready, game_over, draw = 0; winner=0.

FSM states: CLR, IDLE, WRITE, WAIT, CHECK, DONE.

CLR:
- board_rst=0 for exactly CLR_CYC cycles, then IDLE.
- Heights, move_cnt and winner are cleared on entry; Player=1.

IDLE:
- move_ready=1.
- On move_valid & move_ready:
  - Illegal if move_col >= COLS, or height[move_col] == ROWS. Then illegal=1 next cycle, state stays IDLE, Player unchanged, nothing written.
  - Otherwise latch colval=move_col, row = ROWS-1-height[move_col], waddr=row*4; increment height and move_cnt; go WRITE.

WRITE:
- wr_en=1 for one cycle; Player, colval, waddr stable. Then WAIT.
- Player/colval/waddr hold their values until the next accepted move.

WAIT:
- Counts WIN_LAT-1 cycles, then CHECK, so winflag is sampled WIN_LAT cycles after the wr_en cycle.

CHECK (one cycle, samples winflag):
- winflag=1 → winner = Player ? 1 : 2; game_over=1; go DONE.
- Else if move_cnt == ROWS*COLS → draw=1; game_over=1; go DONE.
- Else toggle Player; go IDLE.

DONE:
- game_over, winner and draw hold; move_ready=0; move_valid is ignored.

new_game:
- new_game=1 in any state forces CLR next cycle.
- It overrides a simultaneous move accept; a write in flight is abandoned.
- Holding new_game high keeps the block in CLR.

winflag outside CHECK is ignored.

Width rules:
- height counters are 3 bits each, saturate at ROWS.
- waddr = {row,2'b00}, truncated to 5 bits (max 20).

Decomposition:
- Package c4_pkg: ROWS/COLS constants, state enum, PLAYER1=1'b1 / PLAYER2=1'b0, winner encodings.
- One sub-module c4_col_heights: the COLS fill counters with full flags, landing-row output, and sync clear.

Test Plan:
1. Reset, then new_game=0 → board_rst low exactly 2 cycles; move_ready=1 on the cycle after; Player=1, move_cnt=0.
2. Accept col 3 → wr_en one cycle with Player=1, colval=3, waddr=20. Accept col 3 again → Player=0, waddr=16. move_cnt=2.
3. Alternate cols 0,6,0,6,0,6,0 with a win-check model asserting winflag on the 7th move → winner=1, game_over=1 when CHECK samples winflag 3 cycles after wr_en; later moves ignored.
4. Fill col 2 with 6 moves, then request col 2 → illegal pulse, no wr_en, Player unchanged. Request col 7 → illegal.
5. Play 42 legal moves with winflag held 0 → after the last CHECK, draw=1, winner=0, game_over=1, move_cnt=42.
6. Assert new_game during WAIT, and separately in the same cycle as a move_valid accept → no further wr_en; CLR sequence runs; heights and move_cnt are 0 afterwards. rst low mid-WRITE → all outputs at reset values.
